// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: 4-digit multiplexed 7-segment driver with dead time,
// leading-zero blanking and frame-synchronous value updates.
module seven_seg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD        = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEADC = CW'(DEAD);
    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [3:0]    pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic          pend_v_q, pend_v_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          fd_q, fd_d;
    logic          bnd, blank, dp, dead, wrap;
    logic [3:0]    nib;
    always_comb begin
        wrap       = cnt_q == LAST;
        bnd        = wrap && idx_q == 2'd3;
        cnt_d      = wrap ? '0 : cnt_q + 1'b1;
        idx_d      = wrap ? idx_q + 2'd1 : idx_q;
        pend_val_d = load ? value : pend_val_q;
        pend_dp_d  = load ? dp_in : pend_dp_q;
        pend_v_d   = !bnd && (load || pend_v_q);
        // a load on the boundary cycle bypasses pend so it is shown next frame
        disp_val_d = (bnd && load) ? value : (bnd && pend_v_q) ? pend_val_q : disp_val_q;
        disp_dp_d  = (bnd && load) ? dp_in : (bnd && pend_v_q) ? pend_dp_q : disp_dp_q;
        nib        = disp_val_q[{idx_q, 2'b00} +: 4];
        blank      = blank_lz && idx_q != 2'd0 && (disp_val_q >> {idx_q, 2'b00}) == 16'h0;
        dp         = disp_dp_q[idx_q];
        dead       = cnt_q < DEADC;
        an_d       = (dead || (blank && !dp)) ? 4'b0 : 4'b1 << idx_q;
        seg_d      = dead ? 8'h0 : {dp, blank ? 7'h0 : HEX[nib]};
        fd_d       = bnd;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_v_q   <= 1'b0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            an_q       <= '0;
            seg_q      <= '0;
            fd_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_v_q   <= pend_v_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            fd_q       <= fd_d;
        end
    end
    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: randomized and directed checks against a
// time-based model of the scanned display.
module tb_seven_seg_scan_driver;
    localparam int R = 8;
    localparam int D = 2;
    localparam int F = 4 * R;
    logic clk = 0, rst = 1, load = 0, blank_lz = 0;
    logic [15:0] value = 0;
    logic [3:0] dp_in = 0, an;
    logic [7:0] seg;
    logic frame_done;
    int vecs = 0, errs = 0;
    seven_seg_scan_driver #(.REFRESH_DIV(R), .DEAD(D)) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .an(an), .seg(seg), .frame_done(frame_done)
    );
    always #5 clk = ~clk;
    string hex_s [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    logic [6:0] hex_m [16];
    initial for (int k = 0; k < 16; k++) begin
        hex_m[k] = 7'h0;
        for (int c = 0; c < hex_s[k].len(); c++) hex_m[k][int'(hex_s[k][c]) - 97] = 1'b1;
    end
    // model: position in the frame comes purely from edges counted since reset
    int t = 0, m_slot, m_dg;
    logic [15:0] m_disp = 0, m_pend = 0, m_up;
    logic [3:0] m_ddp = 0, m_pdp = 0, exp_an = 0;
    logic [7:0] exp_seg = 0;
    logic m_pv = 0, exp_fd = 0, m_bnd, m_blk, m_dp;
    always_comb begin
        m_slot = t % R;
        m_dg   = (t / R) % 4;
        m_bnd  = m_slot == R - 1 && m_dg == 3;
        m_up   = m_disp >> (4 * m_dg);
        m_blk  = blank_lz && m_dg > 0 && m_up == 16'h0;
        m_dp   = m_ddp[m_dg];
    end
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= 0; m_disp <= 0; m_ddp <= 0; m_pend <= 0; m_pdp <= 0; m_pv <= 0;
            exp_an <= 0; exp_seg <= 0; exp_fd <= 0;
        end else begin
            exp_fd  <= m_bnd;
            exp_an  <= (m_slot < D || (m_blk && !m_dp)) ? 4'h0 : 4'(1 << m_dg);
            exp_seg <= m_slot < D ? 8'h0 : {m_dp, m_blk ? 7'h0 : hex_m[m_up[3:0]]};
            if (m_bnd) begin
                m_pv <= 0;
                if (load) begin m_disp <= value; m_ddp <= dp_in; end
                else if (m_pv) begin m_disp <= m_pend; m_ddp <= m_pdp; end
            end else if (load) begin
                m_pend <= value; m_pdp <= dp_in; m_pv <= 1;
            end
            t <= t + 1;
        end
    end
    task automatic go(input int pos);
        for (int i = 0; i <= F && (t % F) != pos; i++) @(negedge clk);
        if ((t % F) != pos) begin errs++; $display("FAIL go: frame position %0d not reached", pos); end
    endtask
    task automatic pulse(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1;
    endtask
    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        vecs++;
        if ({an, seg, frame_done} !== 13'h0) begin errs++; $display("FAIL reset_state: an=%b seg=%h fd=%b want 0", an, seg, frame_done); end
        rst = 0;
        pulse(16'h1234, 4'h0);
        for (int i = 0; i < 3 * F; i++) begin
            @(negedge clk); vecs++; load = 0;
            if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd) begin
                errs++; $display("FAIL reset_scan t=%0d: an=%b/%b seg=%h/%h fd=%b/%b", t, an, exp_an, seg, exp_seg, frame_done, exp_fd);
            end
            if (i == D - 1 && an !== 4'b0000) begin errs++; $display("FAIL first_dead: an=%b want 0000", an); end
            if (i == D && an !== 4'b0001) begin errs++; $display("FAIL first_enable: an=%b want 0001", an); end
        end
    endtask
    task automatic test_tear_free;
        int fds = 0;
        go(R + 3);
        pulse(16'hABCD, 4'h0);
        for (int i = 0; i <= 2 * F && !(fds > 0 && (t % F) == D + 1); i++) begin
            @(negedge clk); vecs++; load = 0;
            fds += int'(frame_done);
            if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd) begin
                errs++; $display("FAIL tear_free t=%0d: an=%b/%b seg=%h/%h fd=%b/%b", t, an, exp_an, seg, exp_seg, frame_done, exp_fd);
            end
        end
        vecs++;
        if (fds !== 1) begin errs++; $display("FAIL tear_fd_count: got %0d want 1", fds); end
        vecs++;
        if (an !== 4'b0001 || seg !== 8'h5E) begin errs++; $display("FAIL tear_digit0: an=%b seg=%h want 0001/5e", an, seg); end
    endtask
    task automatic test_back_to_back;
        go(F - 1);
        pulse(16'h5678, 4'h0);
        for (int i = 0; i < F; i++) begin
            @(negedge clk); vecs++; load = 0;
            if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd) begin
                errs++; $display("FAIL boundary_load t=%0d: an=%b/%b seg=%h/%h", t, an, exp_an, seg, exp_seg);
            end
            if ((t % F) == D + 1 && seg !== 8'h7F) begin errs++; $display("FAIL boundary_digit0: seg=%h want 7f", seg); end
        end
        go(2);
        pulse(16'h1111, 4'h0);
        @(negedge clk); load = 0;
        go(2 * R + 2);
        pulse(16'h2222, 4'h0);
        for (int i = 0; i < 2 * F; i++) begin
            @(negedge clk); vecs++; load = 0;
            if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd) begin
                errs++; $display("FAIL double_load t=%0d: an=%b/%b seg=%h/%h", t, an, exp_an, seg, exp_seg);
            end
            if (an != 0 && seg[6:0] === 7'h06) begin errs++; $display("FAIL double_load_stale: seg=%h shows 1", seg); end
        end
    endtask
    task automatic test_blanking;
        blank_lz = 1;
        go(0);
        pulse(16'h0005, 4'b0100);
        for (int i = 0; i < 3 * F; i++) begin
            @(negedge clk); vecs++; load = 0;
            if (i == 2 * F) blank_lz = 0;
            if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd) begin
                errs++; $display("FAIL blanking t=%0d blz=%b: an=%b/%b seg=%h/%h", t, blank_lz, an, exp_an, seg, exp_seg);
            end
            if (i >= F && i < 2 * F && (t % F) == 2 * R + D + 1 && (an !== 4'b0100 || seg !== 8'h80)) begin
                errs++; $display("FAIL blank_dp_digit2: an=%b seg=%h want 0100/80", an, seg);
            end
        end
    endtask
    task automatic test_hex_digits;
        logic [15:0] vals [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        for (int k = 0; k < 4; k++) begin
            go(R);
            pulse(vals[k], 4'(k * 5));
            for (int i = 0; i < 2 * F; i++) begin
                @(negedge clk); vecs++; load = 0;
                if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd) begin
                    errs++; $display("FAIL hex %h t=%0d: an=%b/%b seg=%h/%h", vals[k], t, an, exp_an, seg, exp_seg);
                end
            end
        end
    endtask
    task automatic test_random;
        for (int k = 0; k < 10; k++) begin
            go($urandom_range(0, F - 1));
            blank_lz = 1'($urandom);
            pulse(16'($urandom) >> (4 * $urandom_range(0, 3)), 4'($urandom));
            for (int i = 0; i < F + R; i++) begin
                @(negedge clk); vecs++; load = 0;
                if (i == R) blank_lz = 1'($urandom);
                if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd) begin
                    errs++; $display("FAIL random t=%0d: an=%b/%b seg=%h/%h fd=%b/%b", t, an, exp_an, seg, exp_seg, frame_done, exp_fd);
                end
            end
        end
        blank_lz = 0;
    endtask
    task automatic test_mid_reset;
        go(R + 2);
        pulse(16'hC0DE, 4'hF);
        go(2 * R + 4);
        #1 rst = 1;
        #1 vecs++;
        if ({an, seg, frame_done} !== 13'h0) begin errs++; $display("FAIL async_reset: an=%b seg=%h fd=%b want 0", an, seg, frame_done); end
        load = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 2 * F; i++) begin
            @(negedge clk); vecs++;
            if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd) begin
                errs++; $display("FAIL post_reset t=%0d: an=%b/%b seg=%h/%h fd=%b/%b", t, an, exp_an, seg, exp_seg, frame_done, exp_fd);
            end
            if (i == D && (an !== 4'b0001 || seg !== 8'h3F)) begin errs++; $display("FAIL restart_digit0: an=%b seg=%h want 0001/3f", an, seg); end
        end
    endtask
    initial begin
        test_reset;
        test_tear_free;
        test_back_to_back;
        test_blanking;
        test_hex_digits;
        test_random;
        test_mid_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
